// File: rtl/calc2_dispatch_sched.sv
// calc2_dispatch_sched: central issue scheduler for the calc2 datapath.
//
// Four requester ports present commands that are held until acked. Commands
// 1/2 go to the adder unit and 5/6 go to the shifter unit. Any other non-zero
// command is rejected. The scheduler acks a rejected command at once and
// reports it one cycle later. Each unit has its own round-robin arbiter and
// grants at most one port per cycle. A 16-entry scoreboard indexed by
// {port index, tag} blocks reuse of an in-flight tag. A per-unit counter caps
// the number of outstanding operations at MAX_OUT.
//
// Ports:
//   c_clk, reset                 clock, asynchronous active-low reset
//   reqN_cmd_in/tag_in/data*_in  port N request (N=1..4); cmd 0 = idle
//   reqN_ack                     combinational accept for port N
//   adder_* / shift_*            registered dispatch to each unit
//                                (*_tag = {port index 0..3, tag})
//   adder_done(_tag), shift_done(_tag)  retire notifications from the units
//   portN_invalid_op/_tag        registered one-cycle reject report
//   sched_err                    sticky protocol error flag
//
// Handshake: a request is accepted exactly in a cycle where cmd != 0 and
// reqN_ack = 1. The requester keeps cmd/tag/data stable until that cycle.
// Dispatch has no backpressure; *_vld is a one-cycle qualifier.
module calc2_dispatch_sched #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req1_cmd_in,
    input  logic [1:0]  req1_tag_in,
    input  logic [31:0] req1_data1_in,
    input  logic [31:0] req1_data2_in,
    output logic        req1_ack,
    input  logic [3:0]  req2_cmd_in,
    input  logic [1:0]  req2_tag_in,
    input  logic [31:0] req2_data1_in,
    input  logic [31:0] req2_data2_in,
    output logic        req2_ack,
    input  logic [3:0]  req3_cmd_in,
    input  logic [1:0]  req3_tag_in,
    input  logic [31:0] req3_data1_in,
    input  logic [31:0] req3_data2_in,
    output logic        req3_ack,
    input  logic [3:0]  req4_cmd_in,
    input  logic [1:0]  req4_tag_in,
    input  logic [31:0] req4_data1_in,
    input  logic [31:0] req4_data2_in,
    output logic        req4_ack,
    output logic        adder_vld,
    output logic [3:0]  adder_cmd,
    output logic [3:0]  adder_tag,
    output logic [31:0] adder_data1,
    output logic [31:0] adder_data2,
    output logic        shift_vld,
    output logic [3:0]  shift_cmd,
    output logic [3:0]  shift_tag,
    output logic [31:0] shift_data1,
    output logic [31:0] shift_data2,
    input  logic        adder_done,
    input  logic [3:0]  adder_done_tag,
    input  logic        shift_done,
    input  logic [3:0]  shift_done_tag,
    output logic        port1_invalid_op,
    output logic [1:0]  port1_invalid_tag,
    output logic        port2_invalid_op,
    output logic [1:0]  port2_invalid_tag,
    output logic        port3_invalid_op,
    output logic [1:0]  port3_invalid_tag,
    output logic        port4_invalid_op,
    output logic [1:0]  port4_invalid_tag,
    output logic        sched_err
);

    logic [3:0]  w_cmd [4];
    logic [1:0]  w_tag [4];
    logic [31:0] w_d1  [4];
    logic [31:0] w_d2  [4];

    assign w_cmd[0] = req1_cmd_in;  assign w_tag[0] = req1_tag_in;
    assign w_cmd[1] = req2_cmd_in;  assign w_tag[1] = req2_tag_in;
    assign w_cmd[2] = req3_cmd_in;  assign w_tag[2] = req3_tag_in;
    assign w_cmd[3] = req4_cmd_in;  assign w_tag[3] = req4_tag_in;
    assign w_d1[0]  = req1_data1_in; assign w_d2[0] = req1_data2_in;
    assign w_d1[1]  = req2_data1_in; assign w_d2[1] = req2_data2_in;
    assign w_d1[2]  = req3_data1_in; assign w_d2[2] = req3_data2_in;
    assign w_d1[3]  = req4_data1_in; assign w_d2[3] = req4_data2_in;

    logic [15:0] r_sb;
    logic [3:0]  r_add_cnt, r_sh_cnt;
    logic [1:0]  r_add_ptr, r_sh_ptr;
    logic        r_add_vld, r_sh_vld, r_err;
    logic [3:0]  r_add_cmd, r_add_tag, r_sh_cmd, r_sh_tag;
    logic [31:0] r_add_d1, r_add_d2, r_sh_d1, r_sh_d2;
    logic [3:0]  r_inv_op;
    logic [1:0]  r_inv_tag [4];

    logic [3:0]  w_add_elig, w_sh_elig, w_inv, w_add_gnt, w_sh_gnt, w_ack;
    logic [1:0]  w_add_idx, w_sh_idx;
    logic        w_add_any, w_sh_any, w_add_room, w_sh_room;
    logic        w_add_dec, w_sh_dec, w_err;
    logic [15:0] w_set, w_clr;

    // First eligible port at or after ptr, in port order with wrap.
    function automatic logic [3:0] rr_pick(input logic [3:0] elig, input logic [1:0] ptr);
        logic [3:0] g;
        logic [1:0] idx;
        g = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (elig[idx] && (g == 4'b0000)) g[idx] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [1:0] enc4(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = i[1:0];
        return r;
    endfunction

    assign w_add_room = (r_add_cnt < 4'(MAX_OUT));
    assign w_sh_room  = (r_sh_cnt  < 4'(MAX_OUT));

    // Acks are masked while reset is asserted so a held request cannot
    // appear accepted when the scheduler is not tracking it.
    always_comb begin
        w_add_elig = 4'b0000;
        w_sh_elig  = 4'b0000;
        w_inv      = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (reset && !r_sb[{i[1:0], w_tag[i]}]) begin
                w_add_elig[i] = ((w_cmd[i] == 4'd1) || (w_cmd[i] == 4'd2)) && w_add_room;
                w_sh_elig[i]  = ((w_cmd[i] == 4'd5) || (w_cmd[i] == 4'd6)) && w_sh_room;
            end
            w_inv[i] = reset && (w_cmd[i] != 4'd0) && (w_cmd[i] != 4'd1) && (w_cmd[i] != 4'd2)
                       && (w_cmd[i] != 4'd5) && (w_cmd[i] != 4'd6);
        end
    end

    assign w_add_gnt = rr_pick(w_add_elig, r_add_ptr);
    assign w_sh_gnt  = rr_pick(w_sh_elig, r_sh_ptr);
    assign w_add_idx = enc4(w_add_gnt);
    assign w_sh_idx  = enc4(w_sh_gnt);
    assign w_add_any = |w_add_gnt;
    assign w_sh_any  = |w_sh_gnt;
    assign w_ack     = w_add_gnt | w_sh_gnt | w_inv;

    assign req1_ack = w_ack[0];
    assign req2_ack = w_ack[1];
    assign req3_ack = w_ack[2];
    assign req4_ack = w_ack[3];

    // Set has priority over clear; a legal flow never hits the same bit
    // with both, since eligibility reads the registered bit.
    always_comb begin
        w_set = 16'h0000;
        w_clr = 16'h0000;
        if (w_add_any) w_set[{w_add_idx, w_tag[w_add_idx]}] = 1'b1;
        if (w_sh_any)  w_set[{w_sh_idx,  w_tag[w_sh_idx]}]  = 1'b1;
        if (adder_done) w_clr[adder_done_tag] = 1'b1;
        if (shift_done) w_clr[shift_done_tag] = 1'b1;
    end

    assign w_add_dec = adder_done && (r_add_cnt != 4'd0);
    assign w_sh_dec  = shift_done && (r_sh_cnt  != 4'd0);
    assign w_err     = (adder_done && ((r_add_cnt == 4'd0) || !r_sb[adder_done_tag]))
                    || (shift_done && ((r_sh_cnt  == 4'd0) || !r_sb[shift_done_tag]));

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_sb      <= 16'h0000;
            r_add_cnt <= 4'd0;
            r_sh_cnt  <= 4'd0;
            r_add_ptr <= 2'd0;
            r_sh_ptr  <= 2'd0;
            r_add_vld <= 1'b0;
            r_sh_vld  <= 1'b0;
            r_add_cmd <= 4'd0;
            r_add_tag <= 4'd0;
            r_sh_cmd  <= 4'd0;
            r_sh_tag  <= 4'd0;
            r_add_d1  <= 32'd0;
            r_add_d2  <= 32'd0;
            r_sh_d1   <= 32'd0;
            r_sh_d2   <= 32'd0;
            r_err     <= 1'b0;
            r_inv_op  <= 4'b0000;
            for (int i = 0; i < 4; i++) r_inv_tag[i] <= 2'd0;
        end else begin
            r_sb <= (r_sb & ~w_clr) | w_set;
            if (w_add_any && !w_add_dec)      r_add_cnt <= r_add_cnt + 4'd1;
            else if (!w_add_any && w_add_dec) r_add_cnt <= r_add_cnt - 4'd1;
            if (w_sh_any && !w_sh_dec)        r_sh_cnt  <= r_sh_cnt + 4'd1;
            else if (!w_sh_any && w_sh_dec)   r_sh_cnt  <= r_sh_cnt - 4'd1;

            r_add_vld <= w_add_any;
            if (w_add_any) begin
                r_add_ptr <= w_add_idx + 2'd1;
                r_add_cmd <= w_cmd[w_add_idx];
                r_add_tag <= {w_add_idx, w_tag[w_add_idx]};
                r_add_d1  <= w_d1[w_add_idx];
                r_add_d2  <= w_d2[w_add_idx];
            end
            r_sh_vld <= w_sh_any;
            if (w_sh_any) begin
                r_sh_ptr <= w_sh_idx + 2'd1;
                r_sh_cmd <= w_cmd[w_sh_idx];
                r_sh_tag <= {w_sh_idx, w_tag[w_sh_idx]};
                r_sh_d1  <= w_d1[w_sh_idx];
                r_sh_d2  <= w_d2[w_sh_idx];
            end

            if (w_err) r_err <= 1'b1;
            r_inv_op <= w_inv;
            for (int i = 0; i < 4; i++) r_inv_tag[i] <= w_inv[i] ? w_tag[i] : 2'd0;
        end
    end

    assign adder_vld   = r_add_vld;
    assign adder_cmd   = r_add_cmd;
    assign adder_tag   = r_add_tag;
    assign adder_data1 = r_add_d1;
    assign adder_data2 = r_add_d2;
    assign shift_vld   = r_sh_vld;
    assign shift_cmd   = r_sh_cmd;
    assign shift_tag   = r_sh_tag;
    assign shift_data1 = r_sh_d1;
    assign shift_data2 = r_sh_d2;
    assign sched_err   = r_err;

    assign port1_invalid_op  = r_inv_op[0];
    assign port2_invalid_op  = r_inv_op[1];
    assign port3_invalid_op  = r_inv_op[2];
    assign port4_invalid_op  = r_inv_op[3];
    assign port1_invalid_tag = r_inv_tag[0];
    assign port2_invalid_tag = r_inv_tag[1];
    assign port3_invalid_tag = r_inv_tag[2];
    assign port4_invalid_tag = r_inv_tag[3];

endmodule

// File: tb/tb_calc2_dispatch_sched.sv
module tb_calc2_dispatch_sched;

    logic c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    logic        reset;
    logic [3:0]  cmd [4];
    logic [1:0]  tg  [4];
    logic [31:0] da  [4];
    logic [31:0] db  [4];
    logic        adder_done, shift_done;
    logic [3:0]  adder_done_tag, shift_done_tag;

    wire [3:0]  ack;
    wire [3:0]  inv_op;
    wire [1:0]  inv_tag [4];
    wire        adder_vld, shift_vld, sched_err;
    wire [3:0]  adder_cmd, adder_tag, shift_cmd, shift_tag;
    wire [31:0] adder_data1, adder_data2, shift_data1, shift_data2;

    int total = 0;
    int bad   = 0;
    logic [71:0] exp_add_q[$];
    logic [71:0] exp_sh_q[$];
    logic [3:0]  exp_inv_q[$];

    calc2_dispatch_sched #(.MAX_OUT(4)) dut (
        .c_clk(c_clk), .reset(reset),
        .req1_cmd_in(cmd[0]), .req1_tag_in(tg[0]), .req1_data1_in(da[0]), .req1_data2_in(db[0]), .req1_ack(ack[0]),
        .req2_cmd_in(cmd[1]), .req2_tag_in(tg[1]), .req2_data1_in(da[1]), .req2_data2_in(db[1]), .req2_ack(ack[1]),
        .req3_cmd_in(cmd[2]), .req3_tag_in(tg[2]), .req3_data1_in(da[2]), .req3_data2_in(db[2]), .req3_ack(ack[2]),
        .req4_cmd_in(cmd[3]), .req4_tag_in(tg[3]), .req4_data1_in(da[3]), .req4_data2_in(db[3]), .req4_ack(ack[3]),
        .adder_vld(adder_vld), .adder_cmd(adder_cmd), .adder_tag(adder_tag),
        .adder_data1(adder_data1), .adder_data2(adder_data2),
        .shift_vld(shift_vld), .shift_cmd(shift_cmd), .shift_tag(shift_tag),
        .shift_data1(shift_data1), .shift_data2(shift_data2),
        .adder_done(adder_done), .adder_done_tag(adder_done_tag),
        .shift_done(shift_done), .shift_done_tag(shift_done_tag),
        .port1_invalid_op(inv_op[0]), .port1_invalid_tag(inv_tag[0]),
        .port2_invalid_op(inv_op[1]), .port2_invalid_tag(inv_tag[1]),
        .port3_invalid_op(inv_op[2]), .port3_invalid_tag(inv_tag[2]),
        .port4_invalid_op(inv_op[3]), .port4_invalid_tag(inv_tag[3]),
        .sched_err(sched_err)
    );

    task automatic chk(input string name, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic idle_all();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0; tg[p] = 2'd0; da[p] = 32'd0; db[p] = 32'd0;
        end
    endtask

    task automatic put(input int p, input logic [3:0] c, input logic [1:0] t,
                       input logic [31:0] a, input logic [31:0] b);
        cmd[p] = c; tg[p] = t; da[p] = a; db[p] = b;
    endtask

    task automatic ack_is(input string name, input logic [3:0] exp);
        #1;
        chk(name, ack, exp);
    endtask

    task automatic push_add(input int p);
        exp_add_q.push_back({cmd[p], p[1:0], tg[p], da[p], db[p]});
    endtask

    task automatic push_sh(input int p);
        exp_sh_q.push_back({cmd[p], p[1:0], tg[p], da[p], db[p]});
    endtask

    task automatic push_inv(input int p);
        exp_inv_q.push_back({p[1:0], tg[p]});
    endtask

    function automatic logic [31:0] rnd();
        return $urandom_range(0, 32'h7FFF_FFFF);
    endfunction

    // Scoreboard: every dispatch and reject pulse must match the oldest
    // expected entry for that stream.
    always @(negedge c_clk) begin
        logic [71:0] e;
        logic [3:0]  e4;
        if (adder_vld) begin
            if (exp_add_q.size() == 0) chk("add_unexpected", 1, 0);
            else begin
                e = exp_add_q.pop_front();
                chk("add_dispatch", {adder_cmd, adder_tag, adder_data1, adder_data2}, e);
            end
        end
        if (shift_vld) begin
            if (exp_sh_q.size() == 0) chk("shift_unexpected", 1, 0);
            else begin
                e = exp_sh_q.pop_front();
                chk("shift_dispatch", {shift_cmd, shift_tag, shift_data1, shift_data2}, e);
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (inv_op[p]) begin
                if (exp_inv_q.size() == 0) chk("inv_unexpected", 1, 0);
                else begin
                    e4 = exp_inv_q.pop_front();
                    chk("inv_pulse", {p[1:0], inv_tag[p]}, e4);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_all();
        adder_done = 1'b0; adder_done_tag = 4'd0;
        shift_done = 1'b0; shift_done_tag = 4'd0;
        #2 reset = 1'b0;
        repeat (3) @(posedge c_clk);
        #1;
        chk("rst_adder_vld", adder_vld, 0);
        chk("rst_shift_vld", shift_vld, 0);
        chk("rst_adder_cmd", adder_cmd, 0);
        chk("rst_adder_tag", adder_tag, 0);
        chk("rst_adder_d1",  adder_data1, 0);
        chk("rst_shift_d2",  shift_data2, 0);
        chk("rst_inv_op",    inv_op, 0);
        chk("rst_err",       sched_err, 0);
        reset = 1'b1;

        // Four simultaneous adds, pointer at port1; port2 follows with a shl.
        for (int p = 0; p < 4; p++) put(p, 4'd1, 2'd0, rnd(), rnd());
        ack_is("rr_c0", 4'b0001); push_add(0); tick(); cmd[0] = 4'd0;
        ack_is("rr_c1", 4'b0010); push_add(1); tick(); put(1, 4'd5, 2'd1, rnd(), rnd());
        ack_is("rr_c2", 4'b0110); push_add(2); push_sh(1); tick();
        cmd[1] = 4'd0; cmd[2] = 4'd0;
        ack_is("rr_c3", 4'b1000); push_add(3); tick(); cmd[3] = 4'd0;
        for (int i = 0; i < 4; i++) begin
            adder_done = 1'b1; adder_done_tag = {i[1:0], 2'b00};
            if (i == 0) begin shift_done = 1'b1; shift_done_tag = 4'b0101; end
            tick();
            adder_done = 1'b0; shift_done = 1'b0;
        end
        chk("rr_no_err", sched_err, 0);

        // Outstanding cap on the adder.
        for (int t = 0; t < 4; t++) begin
            put(0, (t % 2 == 0) ? 4'd1 : 4'd2, t[1:0], rnd(), rnd());
            ack_is("cap_fill", 4'b0001); push_add(0); tick();
        end
        cmd[0] = 4'd0;
        put(1, 4'd2, 2'd0, rnd(), rnd());
        ack_is("cap_block0", 4'b0000); tick();
        ack_is("cap_block1", 4'b0000); tick();
        adder_done = 1'b1; adder_done_tag = 4'b0000;
        ack_is("cap_block_done", 4'b0000); tick();
        adder_done = 1'b0;
        ack_is("cap_release", 4'b0010); push_add(1); tick(); cmd[1] = 4'd0;
        for (int i = 1; i < 5; i++) begin
            adder_done = 1'b1; adder_done_tag = 4'(i);
            tick();
            adder_done = 1'b0;
        end
        chk("cap_no_err", sched_err, 0);

        // Single add with scoreboard blocking of the same tag.
        put(0, 4'd1, 2'd2, 32'd5, 32'd7);
        ack_is("one_ack", 4'b0001); push_add(0); tick();
        chk("one_vld", adder_vld, 1);
        chk("one_tag", adder_tag, 4'b0010);
        adder_done = 1'b1; adder_done_tag = 4'b0010;
        ack_is("one_sb_block", 4'b0000); tick();
        adder_done = 1'b0;
        ack_is("one_reissue", 4'b0001); push_add(0); tick(); cmd[0] = 4'd0;
        adder_done = 1'b1; adder_done_tag = 4'b0010; tick(); adder_done = 1'b0;

        // Duplicate tag on port3 across units.
        put(2, 4'd6, 2'd1, rnd(), rnd());
        ack_is("dup_first", 4'b0100); push_sh(2); tick();
        put(2, 4'd2, 2'd1, rnd(), rnd());
        ack_is("dup_block0", 4'b0000); tick();
        shift_done = 1'b1; shift_done_tag = 4'b1001;
        ack_is("dup_block_done", 4'b0000); tick();
        shift_done = 1'b0;
        ack_is("dup_reissue", 4'b0100); push_add(2); tick(); cmd[2] = 4'd0;
        adder_done = 1'b1; adder_done_tag = 4'b1001; tick(); adder_done = 1'b0;
        chk("dup_no_err", sched_err, 0);

        // Invalid commands, alone and alongside valid ones.
        put(3, 4'hF, 2'd3, rnd(), rnd());
        ack_is("inv_ack", 4'b1000); push_inv(3); tick(); cmd[3] = 4'd0;
        chk("inv_op_now", inv_op, 4'b1000);
        chk("inv_tag_now", inv_tag[3], 2'd3);
        chk("inv_no_add", adder_vld, 0);
        chk("inv_no_shift", shift_vld, 0);
        put(0, 4'd1, 2'd0, rnd(), rnd());
        put(1, 4'd3, 2'd2, rnd(), rnd());
        put(2, 4'd9, 2'd1, rnd(), rnd());
        put(3, 4'd6, 2'd2, rnd(), rnd());
        ack_is("mix_ack", 4'b1111);
        push_add(0); push_inv(1); push_inv(2); push_sh(3);
        tick(); idle_all();
        adder_done = 1'b1; adder_done_tag = 4'b0000;
        shift_done = 1'b1; shift_done_tag = 4'b1110;
        tick();
        adder_done = 1'b0; shift_done = 1'b0;
        chk("mix_no_err", sched_err, 0);

        // Error flag and asynchronous reset.
        adder_done = 1'b1; adder_done_tag = 4'b0011; tick(); adder_done = 1'b0;
        chk("err_set", sched_err, 1);
        tick();
        chk("err_sticky", sched_err, 1);
        put(0, 4'd1, 2'd0, rnd(), rnd());
        ack_is("pre_rst_ack", 4'b0001); push_add(0); tick();
        #5;
        reset = 1'b0;
        adder_done = 1'b1; adder_done_tag = 4'b0000;
        #1;
        chk("arst_vld", adder_vld, 0);
        chk("arst_cmd", adder_cmd, 0);
        chk("arst_tag", adder_tag, 0);
        chk("arst_d1", adder_data1, 0);
        chk("arst_d2", adder_data2, 0);
        chk("arst_err", sched_err, 0);
        chk("arst_ack", ack, 0);
        tick();
        adder_done = 1'b0;
        reset = 1'b1;
        ack_is("arst_sb_empty", 4'b0001); push_add(0); tick(); cmd[0] = 4'd0;
        chk("arst_done_ignored", sched_err, 0);
        adder_done = 1'b1; adder_done_tag = 4'b0000; tick(); adder_done = 1'b0;
        chk("arst_retire_ok", sched_err, 0);

        repeat (3) tick();
        chk("addq_drained", exp_add_q.size(), 0);
        chk("shq_drained", exp_sh_q.size(), 0);
        chk("invq_drained", exp_inv_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
